// File: rtl/tpu_pkg.sv
// Shared types, default sizes and weight-ROM base offsets for the two-layer DNN sequencer.
package tpu_pkg;

    localparam int unsigned IN_SIZE_D  = 1024;
    localparam int unsigned HID_SIZE_D = 64;
    localparam int unsigned OUT_SIZE_D = 10;
    localparam int unsigned ACC_W_D    = 32;
    localparam int unsigned SHIFT_D    = 8;
    localparam int unsigned WADDR_W_D  = 17;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned IMG_IDX_W  = 10;
    localparam int unsigned ACT_ADDR_W = 6;
    localparam int unsigned CLS_W      = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_L1_BIAS,
        ST_L1_MAC,
        ST_L1_DRAIN,
        ST_L1_WB,
        ST_L2_BIAS,
        ST_L2_MAC,
        ST_L2_DRAIN,
        ST_L2_CMP,
        ST_DONE
    } state_e;

    // Counter width holding 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

    function automatic int unsigned l1_bias_base(input int unsigned in_size,
                                                 input int unsigned hid_size);
        return hid_size * in_size;
    endfunction

    function automatic int unsigned l2_base(input int unsigned in_size,
                                            input int unsigned hid_size);
        return hid_size * in_size + hid_size;
    endfunction

    function automatic int unsigned l2_bias_base(input int unsigned in_size,
                                                 input int unsigned hid_size,
                                                 input int unsigned out_size);
        return l2_base(in_size, hid_size) + out_size * hid_size;
    endfunction

endpackage

// File: rtl/tpu_requant.sv
// Hidden-layer requantisation: ReLU, arithmetic right shift, saturate to an unsigned byte.
module tpu_requant
    import tpu_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_D,
    parameter int unsigned SHIFT = SHIFT_D
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] act_c
);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = $signed(acc) >>> SHIFT;
        act_c   = '0;
        if (acc[ACC_W-1]) begin
            act_c = '0;
        end else if (|shifted[ACC_W-1:DATA_W]) begin
            act_c = '1;
        end else begin
            act_c = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/tpu_layer_sched.sv
// Sequencer for the 1024 -> HID -> 10 DNN: walks neurons/inputs, drives ROM/RAM addresses and
// MAC control, requantises hidden outputs and keeps the running argmax of the output layer.
module tpu_layer_sched
    import tpu_pkg::*;
#(
    parameter int unsigned IN_SIZE  = IN_SIZE_D,
    parameter int unsigned HID_SIZE = HID_SIZE_D,
    parameter int unsigned OUT_SIZE = OUT_SIZE_D,
    parameter int unsigned ACC_W    = ACC_W_D,
    parameter int unsigned SHIFT    = SHIFT_D,
    parameter int unsigned WADDR_W  = WADDR_W_D
) (
    input  logic                  clk,
    input  logic                  iRst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [CLS_W-1:0]      num_out,
    output logic [IMG_IDX_W-1:0]  img_idx,
    input  logic                  img_bit,
    output logic [WADDR_W-1:0]    w_addr,
    input  logic [DATA_W-1:0]     w_data,
    output logic [DATA_W-1:0]     mac_a,
    output logic                  mac_load,
    output logic                  mac_en,
    input  logic [ACC_W-1:0]      acc,
    output logic                  act_we,
    output logic [ACT_ADDR_W-1:0] act_addr,
    output logic [DATA_W-1:0]     act_wdata,
    input  logic [DATA_W-1:0]     act_rdata
);

    localparam int unsigned IW = cnt_w(IN_SIZE);
    localparam int unsigned HW = cnt_w(HID_SIZE);
    localparam int unsigned OW = cnt_w(OUT_SIZE);

    localparam int unsigned L1_BIAS_BASE = l1_bias_base(IN_SIZE, HID_SIZE);
    localparam int unsigned L2_BASE      = l2_base(IN_SIZE, HID_SIZE);
    localparam int unsigned L2_BIAS_BASE = l2_bias_base(IN_SIZE, HID_SIZE, OUT_SIZE);

    state_e                  state_q, state_d;
    logic [HW-1:0]           n_q, n_d;
    logic [IW-1:0]           i_q, i_d;
    logic [HW-1:0]           j_q, j_d;
    logic [OW-1:0]           k_q, k_d;
    logic [OW-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0] best_q, best_d;

    logic                    bit_q, bit_d;
    logic                    l2_q, l2_d;
    logic                    busy_d, done_d, mac_load_d, mac_en_d, act_we_d;
    logic [CLS_W-1:0]        num_out_d;
    logic [IMG_IDX_W-1:0]    img_idx_d;
    logic [WADDR_W-1:0]      w_addr_d;
    logic [ACT_ADDR_W-1:0]   act_addr_d;
    logic [DATA_W-1:0]       req_act;

    // w_data goes straight to the external MAC; the sequencer only supplies its address.
    logic unused_w_data;
    assign unused_w_data = ^w_data;

    tpu_requant #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .acc   (acc),
        .act_c (req_act)
    );

    // Next state, counters and argmax.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        idx_d   = idx_q;
        best_d  = best_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_L1_BIAS;
                    n_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            ST_L1_BIAS: begin
                state_d = ST_L1_MAC;
                i_d     = '0;
            end
            ST_L1_MAC: begin
                if (i_q == IW'(IN_SIZE - 1)) state_d = ST_L1_DRAIN;
                else                         i_d     = i_q + IW'(1);
            end
            ST_L1_DRAIN: state_d = ST_L1_WB;
            ST_L1_WB: begin
                if (n_q == HW'(HID_SIZE - 1)) begin
                    state_d = ST_L2_BIAS;
                    k_d     = '0;
                end else begin
                    state_d = ST_L1_BIAS;
                    n_d     = n_q + HW'(1);
                end
            end
            ST_L2_BIAS: begin
                state_d = ST_L2_MAC;
                j_d     = '0;
            end
            ST_L2_MAC: begin
                if (j_q == HW'(HID_SIZE - 1)) state_d = ST_L2_DRAIN;
                else                          j_d     = j_q + HW'(1);
            end
            ST_L2_DRAIN: state_d = ST_L2_CMP;
            ST_L2_CMP: begin
                // Strict compare: a tie keeps the earlier (lower) class.
                if (k_q == '0 || $signed(acc) > best_q) begin
                    best_d = $signed(acc);
                    idx_d  = k_q;
                end
                if (k_q == OW'(OUT_SIZE - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_L2_BIAS;
                    k_d     = k_q + OW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address-side outputs follow the next state so they line up with the state they belong to.
    always_comb begin
        w_addr_d   = '0;
        img_idx_d  = '0;
        act_addr_d = '0;
        act_we_d   = 1'b0;
        unique case (state_d)
            ST_L1_BIAS: w_addr_d = WADDR_W'(L1_BIAS_BASE + 32'(n_d));
            ST_L1_MAC: begin
                w_addr_d  = WADDR_W'(32'(n_d) * IN_SIZE + 32'(i_d));
                img_idx_d = IMG_IDX_W'(i_d);
            end
            ST_L1_WB: begin
                act_we_d   = 1'b1;
                act_addr_d = ACT_ADDR_W'(n_d);
            end
            ST_L2_BIAS: w_addr_d = WADDR_W'(L2_BIAS_BASE + 32'(k_d));
            ST_L2_MAC: begin
                w_addr_d   = WADDR_W'(L2_BASE + 32'(k_d) * HID_SIZE + 32'(j_d));
                act_addr_d = ACT_ADDR_W'(j_d);
            end
            default: ;
        endcase
    end

    // MAC control lags the address by one cycle to meet the ROM's read latency.
    always_comb begin
        mac_load_d = (state_q == ST_L1_BIAS) || (state_q == ST_L2_BIAS);
        mac_en_d   = (state_q == ST_L1_MAC)  || (state_q == ST_L2_MAC);
        l2_d       = (state_q == ST_L2_MAC);
        bit_d      = img_bit;
        busy_d     = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done_d     = (state_q == ST_DONE);
        num_out_d  = (state_q == ST_DONE) ? CLS_W'(idx_q) : '0;
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            idx_q    <= '0;
            best_q   <= '0;
            bit_q    <= 1'b0;
            l2_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            num_out  <= '0;
            img_idx  <= '0;
            w_addr   <= '0;
            mac_load <= 1'b0;
            mac_en   <= 1'b0;
            act_we   <= 1'b0;
            act_addr <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            idx_q    <= idx_d;
            best_q   <= best_d;
            bit_q    <= bit_d;
            l2_q     <= l2_d;
            busy     <= busy_d;
            done     <= done_d;
            num_out  <= num_out_d;
            img_idx  <= img_idx_d;
            w_addr   <= w_addr_d;
            mac_load <= mac_load_d;
            mac_en   <= mac_en_d;
            act_we   <= act_we_d;
            act_addr <= act_addr_d;
        end
    end

    // Operand and write data track the external MAC/RAM results, which arrive within the cycle.
    assign mac_a     = mac_en ? (l2_q ? act_rdata : {7'b0, bit_q}) : '0;
    assign act_wdata = (state_q == ST_L1_WB) ? req_act : '0;

endmodule

// File: tb/tb_tpu_layer_sched.sv
// Directed bench for tpu_layer_sched at IN=4, HID=2, OUT=3, SHIFT=0 with ROM/RAM/MAC models.
module tb_tpu_layer_sched;

    localparam int unsigned IN   = 4;
    localparam int unsigned HID  = 2;
    localparam int unsigned OUT  = 3;
    localparam int unsigned ACCW = 32;
    localparam int unsigned WAW  = 17;
    localparam int          LAT  = 30;
    localparam int          NCYC = 30;

    // Slot kinds in the expected per-cycle schedule.
    localparam int K_IDLE = 0;
    localparam int K_BIAS = 1;
    localparam int K_W    = 2;
    localparam int K_WB   = 3;

    logic                   clk;
    logic                   iRst;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [3:0]             num_out;
    logic [9:0]             img_idx;
    logic                   img_bit;
    logic [WAW-1:0]         w_addr;
    logic signed [7:0]      w_data;
    logic [7:0]             mac_a;
    logic                   mac_load;
    logic                   mac_en;
    logic signed [ACCW-1:0] acc;
    logic                   act_we;
    logic [5:0]             act_addr;
    logic [7:0]             act_wdata;
    logic [7:0]             act_rdata;

    logic [3:0]             img;
    logic signed [7:0]      rom [0:31];
    logic [7:0]             ram [0:63];

    int n_err;
    int n_chk;
    int exp_addr [NCYC];
    int kind     [NCYC];

    tpu_layer_sched #(
        .IN_SIZE  (IN),
        .HID_SIZE (HID),
        .OUT_SIZE (OUT),
        .ACC_W    (ACCW),
        .SHIFT    (0),
        .WADDR_W  (WAW)
    ) dut (
        .clk       (clk),
        .iRst      (iRst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .num_out   (num_out),
        .img_idx   (img_idx),
        .img_bit   (img_bit),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .mac_a     (mac_a),
        .mac_load  (mac_load),
        .mac_en    (mac_en),
        .acc       (acc),
        .act_we    (act_we),
        .act_addr  (act_addr),
        .act_wdata (act_wdata),
        .act_rdata (act_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign img_bit = (img_idx < 10'd4) ? img[img_idx[1:0]] : 1'b0;

    always @(posedge clk) begin
        w_data <= (w_addr < WAW'(32)) ? rom[w_addr[4:0]] : 8'sd0;
    end

    always @(posedge clk) begin
        if (act_we) ram[act_addr] <= act_wdata;
        act_rdata <= ram[act_addr];
    end

    always @(posedge clk) begin
        if (mac_load)    acc <= int'(w_data);
        else if (mac_en) acc <= acc + int'(mac_a) * int'(w_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({busy, done, num_out, img_idx, mac_load, mac_en, act_we, act_addr}), 0);
        chk({tag, "_waddr"}, 32'(w_addr), 0);
        chk({tag, "_data"}, 32'({mac_a, act_wdata}), 0);
    endtask

    task automatic set_rom(input logic signed [7:0] l1w, input logic signed [7:0] l2w0,
                           input logic signed [7:0] l2w1, input logic signed [7:0] l2w2,
                           input logic signed [7:0] b0, input logic signed [7:0] b1,
                           input logic signed [7:0] b2);
        for (int a = 0; a < 32; a++) rom[a] = 8'sd0;
        for (int a = 0; a < 8; a++) rom[a] = l1w;
        rom[10] = l2w0; rom[11] = l2w0;
        rom[12] = l2w1; rom[13] = l2w1;
        rom[14] = l2w2; rom[15] = l2w2;
        rom[16] = b0;   rom[17] = b1;   rom[18] = b2;
    endtask

    // One full inference; optional stray start pulse at cycle inj.
    task automatic run_net(input string tag, input int inj, input logic [7:0] ea0,
                           input logic [7:0] ea1, input logic [3:0] en);
        int c;
        logic [7:0] ea;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        c = 0;
        while (c < LAT + 10) begin
            if (c == 1) begin
                chk({tag, "_done_low"}, 32'(done), 0);
                chk({tag, "_busy_high"}, 32'(busy), 1);
            end
            if (c >= 2 && done) break;
            if (c < NCYC) begin
                chk({tag, "_waddr"}, 32'(w_addr),
                    (kind[c] == K_BIAS || kind[c] == K_W) ? exp_addr[c] : 0);
                chk({tag, "_mac_load"}, 32'(mac_load), 32'(c > 0 && kind[c-1] == K_BIAS));
                chk({tag, "_mac_en"}, 32'(mac_en), 32'(c > 0 && kind[c-1] == K_W));
                chk({tag, "_act_we"}, 32'(act_we), 32'(kind[c] == K_WB));
                if (kind[c] == K_WB) begin
                    ea = (exp_addr[c] == 0) ? ea0 : ea1;
                    chk({tag, "_act_wdata"}, 32'(act_wdata), 32'(ea));
                    chk({tag, "_act_addr"}, 32'(act_addr), exp_addr[c]);
                end
            end
            start = (c == inj);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, c, LAT);
        chk({tag, "_num_out"}, 32'(num_out), 32'(en));
        chk({tag, "_busy_done"}, 32'(busy), 0);
    endtask

    initial begin
        int s;
        n_err = 0;
        n_chk = 0;
        iRst  = 1'b1;
        start = 1'b0;
        img   = 4'b0000;
        for (int a = 0; a < 64; a++) ram[a] = 8'd0;
        set_rom(8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd0, 8'sd0, 8'sd0);

        // Hand-built schedule: per hidden neuron bias, 4 weights, drain, writeback;
        // per class bias, 2 weights, drain, compare; then DONE.
        s = 0;
        for (int n = 0; n < 2; n++) begin
            kind[s] = K_BIAS; exp_addr[s] = 8 + n; s++;
            for (int i = 0; i < 4; i++) begin
                kind[s] = K_W; exp_addr[s] = n * 4 + i; s++;
            end
            kind[s] = K_IDLE; exp_addr[s] = 0; s++;
            kind[s] = K_WB;   exp_addr[s] = n; s++;
        end
        for (int k = 0; k < 3; k++) begin
            kind[s] = K_BIAS; exp_addr[s] = 16 + k; s++;
            for (int j = 0; j < 2; j++) begin
                kind[s] = K_W; exp_addr[s] = 10 + 2 * k + j; s++;
            end
            kind[s] = K_IDLE; exp_addr[s] = 0; s++;
            kind[s] = K_IDLE; exp_addr[s] = 0; s++;
        end
        kind[s] = K_IDLE; exp_addr[s] = 0;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        iRst = 1'b0;
        @(negedge clk);

        // Class 2 has the heaviest weights: acts 4,4 -> sums 8,8,24.
        img = 4'b1111;
        set_rom(8'sd1, 8'sd1, 8'sd1, 8'sd3, 8'sd0, 8'sd0, 8'sd0);
        run_net("t1", -1, 8'd4, 8'd4, 4'd2);

        // Sparse image, all classes tie at 4; stray start at cycle 10 must be ignored.
        img = 4'b1010;
        set_rom(8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd0, 8'sd0, 8'sd0);
        run_net("t2", 10, 8'd2, 8'd2, 4'd0);

        // Negative layer-1 sums clamp to 0; biases 5,7,7 pick class 1.
        img = 4'b1111;
        set_rom(-8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd5, 8'sd7, 8'sd7);
        run_net("t3", -1, 8'd0, 8'd0, 4'd1);

        // Layer-1 sum 300 saturates to 255; sums 510,510,511.
        set_rom(8'sd75, 8'sd1, 8'sd1, 8'sd1, 8'sd0, 8'sd0, 8'sd1);
        run_net("t4", -1, 8'd255, 8'd255, 4'd2);

        // Asynchronous reset mid-run, then a clean run.
        set_rom(8'sd1, 8'sd1, 8'sd1, 8'sd3, 8'sd0, 8'sd0, 8'sd0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrun_busy", 32'(busy), 1);
        #1 iRst = 1'b1;
        #1 chk_zero("midrun_rst");
        @(negedge clk); iRst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 32'(done), 0);
        run_net("t5", -1, 8'd4, 8'd4, 4'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
